// File: rtl/demux_one_to_four_reg.sv
// Registered 1-to-4 word distributor with valid/ready handshaking.
// Each accepted word lands in the holding register of the addressed port, or all four on broadcast.
module demux_one_to_four_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       sel,
   input  logic             bcast,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] zero,
   output logic [WIDTH-1:0] one,
   output logic [WIDTH-1:0] two,
   output logic [WIDTH-1:0] three,
   output logic [CNT_W-1:0] accept_cnt
);

   logic [3:0]       free;
   logic [3:0]       target;
   logic             accept;
   logic [WIDTH-1:0] port_q [4];

   // A port being drained this cycle counts as free, which allows same-cycle drain/refill.
   // NOTE: every signal gets a value on every path through always_comb, so no latches are inferred.
   always_comb begin
      free     = ~out_valid | out_ready;
      target   = bcast ? 4'b1111 : (4'b0001 << sel);
      in_ready = bcast ? (&free) : free[sel];
      accept   = in_valid & in_ready;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the data registers are reset too, since a cleared port must read back as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 4'b0000;
         accept_cnt <= '0;
         for (int i = 0; i < 4; i++) port_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && target[i]) begin
               port_q[i]    <= in_data;
               out_valid[i] <= 1'b1;
            end else if (out_valid[i] && out_ready[i]) begin
               out_valid[i] <= 1'b0;
            end
         end
         if (accept) accept_cnt <= accept_cnt + CNT_W'(1);
      end
   end

   assign zero  = port_q[0];
   assign one   = port_q[1];
   assign two   = port_q[2];
   assign three = port_q[3];

endmodule

// File: doc/demux_one_to_four_reg.md
# demux_one_to_four_reg

Registered 1-to-4 word distributor with valid/ready handshaking, the write-side counterpart of the datapath's 4:1 32-bit select muxes. One input stream carries a 32-bit word plus a 2-bit SEL; each accepted word is steered into the holding register of the addressed output port, or of all four ports in broadcast mode. Each output port is held until its consumer takes it. It sits between a single producer (decode/writeback stage) and four consumers (register banks, forwarding latches, or peripherals).

## Interface
- WIDTH, 32, data width of input and every output port
- CNT_W, 16, width of the accepted-word counter
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  producer has a word
- IN_READY  out  1  block can accept the presented word this cycle
- SEL  in  2  destination port index, 0..3
- BCAST  in  1  when 1, the word goes to all four ports and SEL is ignored
- IN_DATA  in  WIDTH  input word
- OUT_VALID  out  4  bit i = port i holds a word
- OUT_READY  in  4  bit i = consumer i takes port i's word this cycle
- ZERO, ONE, TWO, THREE  out  WIDTH each  holding registers of ports 0..3
- ACCEPT_CNT  out  CNT_W  count of accepted input words

## Operation
- Per-port "free" term: free[i] = ~OUT_VALID[i] | OUT_READY[i]. A port that is being drained this cycle can be refilled in the same cycle.
- IN_READY:
  - BCAST=0: IN_READY = free[SEL].
  - BCAST=1: IN_READY = free[0]&free[1]&free[2]&free[3].
  - IN_READY is combinational from SEL, BCAST, OUT_VALID and OUT_READY. It does not depend on IN_VALID.
- Accept: accept = IN_VALID & IN_READY.
- Target set T: if BCAST=1, T = 4'b1111; otherwise T = one-hot(SEL).
- Per-port update on each clock edge, for each port i:
  - accept & T[i]: port register <= IN_DATA; OUT_VALID[i] <= 1. This applies whether or not the old word was consumed in the same cycle.
  - else if OUT_VALID[i] & OUT_READY[i]: OUT_VALID[i] <= 0. The data register holds its old value.
  - else: no change.
- Output data is held stable while OUT_VALID[i]=1 and OUT_READY[i]=0. It is never overwritten in that condition, because IN_READY gates all writes.
- OUT_READY[i] is ignored when OUT_VALID[i]=0.
- ACCEPT_CNT increments by 1 per accept, counting a broadcast once. It wraps modulo 2^CNT_W, so all-ones goes to 0.
- Ports are independent: draining or stalling one port never affects acceptance into another port, except under broadcast.
- No data is dropped or duplicated. Each accepted non-broadcast word is presented exactly once on exactly one port.

## Timing
- Reset values (RST=1 at an edge): OUT_VALID=4'b0000; ZERO/ONE/TWO/THREE=0; ACCEPT_CNT=0.
  - IN_READY is 1 in the cycle after reset, because all ports are free.
- RST has priority over every other input. Reset mid-operation discards all held words, ignores any concurrent accept, and clears the count.
- Latency: a word accepted at edge N shows OUT_VALID[i]=1 and the data on port i from just after edge N. It is the earliest consumable at edge N+1.
- Throughput: one word per cycle per stream. This holds even into a single port, provided that consumer asserts OUT_READY continuously (same-cycle drain/refill).
- A stalled addressed port holds IN_READY=0 until its consumer asserts OUT_READY. A producer that switches SEL to a free port is accepted immediately.
- Simultaneous drain of port i and refill of port i: OUT_VALID[i] stays 1 and the data updates to the new word.

## Test plan
- Reset then single write: RST 2 cycles; IN_VALID=1, SEL=2, IN_DATA=32'hDEADBEEF, OUT_READY=0 -> next cycle OUT_VALID=4'b0100, TWO=32'hDEADBEEF, ACCEPT_CNT=1, IN_READY=0 while SEL=2, other outputs 0.
- Backpressure/hold: port 1 filled with 32'h11111111, OUT_READY[1]=0 for 5 cycles, producer presents SEL=1 with 32'h22222222 -> IN_READY=0, ONE stays 32'h11111111; assert OUT_READY[1] -> same edge loads 32'h22222222, OUT_VALID[1] stays 1, ACCEPT_CNT+1.
- Streaming: OUT_READY=4'b1111, 8 back-to-back words with SEL cycling 0,1,2,3 and data 1..8 -> IN_READY=1 every cycle, each port shows its words in order, ACCEPT_CNT=8.
- Broadcast: OUT_VALID[3]=1 stalled, BCAST=1 with data 32'hA5A5A5A5 -> IN_READY=0. Release port 3 -> all four ports show 32'hA5A5A5A5, OUT_VALID=4'b1111, ACCEPT_CNT+1 (not +4).
- Wrap and reset mid-stream: force 65535 accepts, one more -> ACCEPT_CNT=0. With OUT_VALID=4'b1011, assert RST during an accept -> OUT_VALID=0, all data 0, count 0, nothing loaded.
